ram_port_arbiter: RTL

//  Shares one single-port, byte-write, read-first 32-bit RAM (1-cycle registered read) between the

---
 rtl/ram_port_arbiter_if.sv | 38 +++
 rtl/ram_port_arbiter.sv | 71 +++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the shared RAM.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  // Instruction-fetch port
  logic                  ibus_req;
  logic [ADDR_WIDTH-1:0] ibus_addr;
  logic                  ibus_gnt;
  logic                  ibus_rvalid;
  logic [31:0]           ibus_rdata;
  // Data port
  logic                  dbus_req;
  logic [3:0]            dbus_we;
  logic [ADDR_WIDTH-1:0] dbus_addr;
  logic [31:0]           dbus_wdata;
  logic                  dbus_gnt;
  logic                  dbus_rvalid;
  logic [31:0]           dbus_rdata;
  // RAM side
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic [31:0]           ram_dout;

  // Core + RAM side of the bundle
  modport master (
    output ibus_req, ibus_addr, dbus_req, dbus_we, dbus_addr, dbus_wdata, ram_dout,
    input  ibus_gnt, ibus_rvalid, ibus_rdata, dbus_gnt, dbus_rvalid, dbus_rdata,
    input  ram_we, ram_addr, ram_din
  );

  // Arbiter side of the bundle
  modport slave (
    input  ibus_req, ibus_addr, dbus_req, dbus_we, dbus_addr, dbus_wdata, ram_dout,
    output ibus_gnt, ibus_rvalid, ibus_rdata, dbus_gnt, dbus_rvalid, dbus_rdata,
    output ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port read-first RAM between fetch and data buses.
// Data wins by default; a starvation counter forces a fetch grant after
// MAX_STARVE consecutive denied fetch cycles. Read responses return one
// cycle after the grant to whichever port owned the access.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_STARVE = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_STARVE == 0) ? 1 : $clog2(MAX_STARVE + 1);

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  i_pend_q, d_pend_q;
  logic                  force_i_c;
  logic                  ibus_gnt_c, dbus_gnt_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [3:0]            ram_we_c;

  // Per-cycle arbitration, RAM steering and starvation-counter next state
  always_comb begin
    force_i_c    = 1'b0;
    dbus_gnt_c   = 1'b0;
    ibus_gnt_c   = 1'b0;
    ram_addr_c   = bus.ibus_addr;
    ram_we_c     = 4'b0000;
    starve_cnt_d = starve_cnt_q;

    force_i_c  = bus.ibus_req && (starve_cnt_q == CNT_W'(MAX_STARVE));
    dbus_gnt_c = rst_n && bus.dbus_req && !force_i_c;
    ibus_gnt_c = rst_n && bus.ibus_req && !dbus_gnt_c;

    if (dbus_gnt_c) begin
      ram_addr_c = bus.dbus_addr;
      ram_we_c   = bus.dbus_we;
    end

    if (!bus.ibus_req || ibus_gnt_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_W'(MAX_STARVE)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter and response-ownership tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      i_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      i_pend_q     <= ibus_gnt_c;
      d_pend_q     <= dbus_gnt_c;
    end
  end

  assign bus.ibus_gnt    = ibus_gnt_c;
  assign bus.dbus_gnt    = dbus_gnt_c;
  assign bus.ibus_rvalid = i_pend_q;
  assign bus.dbus_rvalid = d_pend_q;
  assign bus.ibus_rdata  = bus.ram_dout;
  assign bus.dbus_rdata  = bus.ram_dout;
  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_we      = ram_we_c;
  assign bus.ram_din     = bus.dbus_wdata;

endmodule
